// File: rtl/regs_hazard_ctrl.sv
// Register-file access controller for a 5-stage RV32I pipeline: tracks in-flight
// destination registers, stalls decode on RAW hazards and drives the RF ports.
module regs_hazard_ctrl #(
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [4:0]             id_rd,
    input  logic                   id_rd_wr,
    input  logic                   flush,
    output logic                   id_stall,
    output logic                   id_issue,
    output logic                   rf_rs_rd_en,
    output logic [4:0]             rf_rd,
    output logic                   rf_rd_wr_en,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int unsigned REG_W = 5;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             wr;
    } entry_t;

    entry_t                 ex_q, ex_d;
    entry_t                 mem_q, mem_d;
    logic [REG_W-1:0]       wb_rd_q, wb_rd_d;
    logic                   wb_wr_en_q, wb_wr_en_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic hazard_rs1;
    logic hazard_rs2;
    logic id_active;

    // An entry only matters if it will actually write a non-zero register.
    function automatic logic writes_gpr(input entry_t e);
        return e.v && e.wr && (e.rd != REG_W'(0));
    endfunction

    function automatic logic src_hazard(input logic used, input logic [REG_W-1:0] rs,
                                        input entry_t ex_e, input entry_t mem_e);
        logic hit_ex;
        logic hit_mem;
        hit_ex  = writes_gpr(ex_e) && (ex_e.rd == rs);
        hit_mem = writes_gpr(mem_e) && (mem_e.rd == rs);
        return used && (rs != REG_W'(0)) && (hit_ex || hit_mem);
    endfunction

    // WB is excluded from hazard detection: its write lands before the read data is used.
    always_comb begin
        hazard_rs1  = 1'b0;
        hazard_rs2  = 1'b0;
        id_active   = 1'b0;
        id_stall    = 1'b0;
        id_issue    = 1'b0;
        ex_d        = '0;
        mem_d       = '0;
        wb_rd_d     = '0;
        wb_wr_en_d  = 1'b0;
        stall_cnt_d = stall_cnt_q;

        hazard_rs1 = src_hazard(id_rs1_used, id_rs1, ex_q, mem_q);
        hazard_rs2 = src_hazard(id_rs2_used, id_rs2, ex_q, mem_q);
        id_active  = id_valid && !flush && !rst;
        id_stall   = id_active && (hazard_rs1 || hazard_rs2);
        id_issue   = id_active && !(hazard_rs1 || hazard_rs2);

        if (id_issue) begin
            ex_d.v  = 1'b1;
            ex_d.rd = id_rd;
            ex_d.wr = id_rd_wr;
        end
        if (!flush) begin
            mem_d = ex_q;
        end
        wb_rd_d    = mem_q.rd;
        wb_wr_en_d = writes_gpr(mem_q);

        if (id_stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_rd_q     <= '0;
            wb_wr_en_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_rd_q     <= wb_rd_d;
            wb_wr_en_q  <= wb_wr_en_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rf_rs_rd_en  = id_issue;
    assign rf_rd        = wb_rd_q;
    assign rf_rd_wr_en  = wb_wr_en_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: doc/regs_hazard_ctrl.md
# regs_hazard_ctrl

Register-file access controller for the RV32I 5-stage pipeline. It tracks destination registers of in-flight instructions (EX, MEM, WB), stalls decode on read-after-write hazards (no bypass network), and drives the register file's read-enable and write-port control. It also keeps a saturating count of stall cycles for performance debug.

## Interface

Parameters:
- `STALL_CNT_W`, default 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `id_valid`  in  1  decode holds a valid instruction.
- `id_rs1`, `id_rs2`  in  5 each  source register addresses.
- `id_rs1_used`, `id_rs2_used`  in  1 each  instruction reads that source.
- `id_rd`  in  5  destination register address.
- `id_rd_wr`  in  1  instruction writes `id_rd`.
- `flush`  in  1  branch/jump redirect: kill ID and EX instructions.
- `id_stall`  out  1  hold the PC and the IF/ID register this cycle.
- `id_issue`  out  1  the ID instruction advances to EX at this edge.
- `rf_rs_rd_en`  out  1  register-file source read enable, equal to `id_issue`.
- `rf_rd`  out  5  register-file write address, from the WB entry.
- `rf_rd_wr_en`  out  1  register-file write enable, from the WB entry.
- `stall_cycles`  out  STALL_CNT_W  count of cycles with `id_stall`=1.

## Operation

- Tracker is a 3-entry shift pipe: EX, MEM, WB. Each entry holds `{v, rd, wr}`.
- An entry is "hazardous" when `v && wr && rd != 0`.
- Hazard on a source `rsN` when `id_rsN_used && rsN != 0` and `rsN` equals the rd of a hazardous EX or MEM entry.
- The WB entry never causes a hazard. Its write lands at the same edge that registers the read address, and read data is combinational from the array after that edge, so the new value is seen.
- `id_stall = id_valid && !flush && (hazard_rs1 || hazard_rs2)`.
- `id_issue = id_valid && !flush && !id_stall`.
- Every cycle, the pipe shifts unconditionally; the downstream stages never stall:
  - EX ← `id_issue ? {1, id_rd, id_rd_wr} : bubble`
  - MEM ← `flush ? bubble : EX`
  - WB ← MEM
- `flush` kills the ID instruction (no issue) and the current EX entry. The MEM and WB entries continue and still write.
- `rf_rd = WB.rd`. `rf_rd_wr_en = WB.v && WB.wr && WB.rd != 0`. A write to x0 is never requested.
- `stall_cycles` increments by 1 each cycle `id_stall`=1 and saturates at all-ones, with no wrap.
- Reset values:
  - All entries have `v`=0.
  - `rd` and `wr` are 0.
  - `stall_cycles` is 0.
  - `rf_rd_wr_en`, `rf_rd`, `id_stall`, `id_issue` and `rf_rs_rd_en` are 0. The last three are forced low while `rst`=1.
- Reset mid-operation discards all in-flight entries. No write is issued in the cycle after reset.

## Timing

- `id_stall`, `id_issue` and `rf_rs_rd_en` are combinational from the ID inputs, `flush`, and the registered EX/MEM entries.
- `rf_rd` and `rf_rd_wr_en` are registered, straight from the WB entry.
- An instruction issued at edge T is in EX for cycle T+1, in MEM for T+2, and in WB for T+3. `rf_rd_wr_en`=1 during cycle T+3.
- A dependent instruction immediately behind its producer stalls 2 cycles and issues in the producer's WB cycle.
- At a distance of 2, the stall is 1 cycle. At a distance of 3 or more, there is no stall.
- Simultaneous `flush` and hazard: `flush` wins, so `id_stall`=0 and `id_issue`=0.
- Both sources matching different entries: stall until neither matches.
- Two in-flight writers to the same rd: the stall holds while either one is in EX or MEM.

## Test plan

- **Back-to-back RAW:** issue `rd=5` at T, then present `rs1=5, rs1_used=1`.
  - Required: `id_stall`=1 for 2 cycles, then `id_issue`=1 in the cycle `rf_rd_wr_en`=1 with `rf_rd`=5.
  - Required: `stall_cycles`=2.
- **x0 and unused sources:** producer `rd=0`, consumer `rs1=0`. Separately, producer `rd=7` with consumer `rs2=7, rs2_used=0`.
  - Required: no stall in either case, and `rf_rd_wr_en` stays 0 for `rd=0`.
- **Distance 2 and 3:** producer `rd=9`, one independent instruction, then a consumer `rs2=9`.
  - Required: exactly 1 stall cycle. With two independent instructions between, 0 stall cycles.
- **Flush:** issue `rd=3`, then assert `flush` the next cycle, with a consumer `rs1=3` arriving after that.
  - Required: the killed EX entry produces no `rf_rd_wr_en`, and the consumer does not stall.
  - Required: an older MEM-stage `rd=4` still writes.
- **Saturation and reset:** with `STALL_CNT_W=4`, hold a hazard for 20 cycles.
  - Required: `stall_cycles` stops at 15.
- **Mid-operation reset:** assert `rst` with 3 valid entries in flight.
  - Required: the next cycle has all outputs 0, `stall_cycles`=0, and no write.
